// File: rtl/time_display_scan.sv
// time_display_scan
//   Captures a binary hh:mm:ss time and converts it to six BCD digits by
//   repeated subtraction of ten.  The digits are then shown on a
//   time-multiplexed 7-segment display.
//
//   Build option: define TWELVE_HOUR_EN for a 12-hour display with a PM flag.
//   When the macro is undefined, the display shows 24-hour time and pm is 0.
//
//   Ports
//     Clk        system clock; all state updates on the rising edge
//     reset      synchronous, active-high reset
//     seconds    binary seconds, 0-59
//     minutes    binary minutes, 0-59
//     hours      binary hours, 0-23
//     sample_req request to capture and convert the current time
//     blank      forces every digit enable low
//     busy       high while a capture is being converted
//     done       one-cycle pulse when new digits reach the display registers
//     range_err  one-cycle pulse when a capture is rejected as out of range
//     seg        active-high segments {g,f,e,d,c,b,a} of the enabled digit
//     dig_en     one-hot digit enable; bit0 = seconds ones, bit5 = hours tens
//     pm         PM indicator (12-hour build only)
module time_display_scan #(
  parameter int SCAN_DIV = 1000
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic [5:0] seconds,
  input  logic [5:0] minutes,
  input  logic [5:0] hours,
  input  logic       sample_req,
  input  logic       blank,
  output logic       busy,
  output logic       done,
  output logic       range_err,
  output logic [6:0] seg,
  output logic [5:0] dig_en,
  output logic       pm
);

  localparam int                PRE_W   = $clog2(SCAN_DIV);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [5:0]       sec_rem_r, min_rem_r, hr_rem_r;
  logic [2:0]       sec_tens_r, min_tens_r, hr_tens_r;
  logic [3:0]       disp_r [6];
  logic [PRE_W-1:0] pre_r;
  logic [2:0]       idx_r;
  logic [3:0]       cur_digit_s;
  logic             legal_s, accept_s, reject_s, all_small_s;
`ifdef TWELVE_HOUR_EN
  logic             pm_cap_r;
`endif

  // Hour mapping applied at capture (identity in the 24-hour build)
  function automatic logic [5:0] map_hours(input logic [5:0] h);
    logic [5:0] r;
`ifdef TWELVE_HOUR_EN
    if (h == 6'd0) begin
      r = 6'd12;
    end else if (h > 6'd12) begin
      r = h - 6'd12;
    end else begin
      r = h;
    end
`else
    r = h;
`endif
    return r;
  endfunction

  // BCD to active-high {g,f,e,d,c,b,a}; non-decimal codes are dark
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // Legality is always judged on the raw hours input, before mapping
  assign legal_s     = (seconds <= 6'd59) && (minutes <= 6'd59) && (hours <= 6'd23);
  assign accept_s    = (state_r == IDLE) && sample_req && legal_s;
  assign reject_s    = (state_r == IDLE) && sample_req && !legal_s;
  assign all_small_s = (sec_rem_r < 6'd10) && (min_rem_r < 6'd10) && (hr_rem_r < 6'd10);

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = CONV;
        end else begin
          state_s = IDLE;
        end
      end
      CONV: begin
        if (all_small_s) begin
          state_s = LOAD;
        end else begin
          state_s = CONV;
        end
      end
      LOAD:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register and status flags; busy follows the CONV state
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_r   <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      range_err <= 1'b0;
    end else begin
      state_r   <= state_s;
      busy      <= (state_s == CONV);
      done      <= (state_r == LOAD);
      range_err <= reject_s;
    end
  end

  // Capture and subtract-by-ten conversion; all three fields step in parallel
  always_ff @(posedge Clk) begin
    if (reset) begin
      sec_rem_r  <= 6'd0;
      min_rem_r  <= 6'd0;
      hr_rem_r   <= 6'd0;
      sec_tens_r <= 3'd0;
      min_tens_r <= 3'd0;
      hr_tens_r  <= 3'd0;
`ifdef TWELVE_HOUR_EN
      pm_cap_r   <= 1'b0;
`endif
    end else if (accept_s) begin
      sec_rem_r  <= seconds;
      min_rem_r  <= minutes;
      hr_rem_r   <= map_hours(hours);
      sec_tens_r <= 3'd0;
      min_tens_r <= 3'd0;
      hr_tens_r  <= 3'd0;
`ifdef TWELVE_HOUR_EN
      pm_cap_r   <= (hours >= 6'd12);
`endif
    end else if ((state_r == CONV) && !all_small_s) begin
      if (sec_rem_r >= 6'd10) begin
        sec_rem_r  <= sec_rem_r - 6'd10;
        sec_tens_r <= sec_tens_r + 3'd1;
      end
      if (min_rem_r >= 6'd10) begin
        min_rem_r  <= min_rem_r - 6'd10;
        min_tens_r <= min_tens_r + 3'd1;
      end
      if (hr_rem_r >= 6'd10) begin
        hr_rem_r  <= hr_rem_r - 6'd10;
        hr_tens_r <= hr_tens_r + 3'd1;
      end
    end
  end

  // Display registers and PM flag change only on the LOAD edge
  always_ff @(posedge Clk) begin
    if (reset) begin
      for (int i = 0; i < 6; i++) begin
        disp_r[i] <= 4'd0;
      end
      pm <= 1'b0;
    end else if (state_r == LOAD) begin
      disp_r[0] <= sec_rem_r[3:0];
      disp_r[1] <= {1'b0, sec_tens_r};
      disp_r[2] <= min_rem_r[3:0];
      disp_r[3] <= {1'b0, min_tens_r};
      disp_r[4] <= hr_rem_r[3:0];
      disp_r[5] <= {1'b0, hr_tens_r};
`ifdef TWELVE_HOUR_EN
      pm        <= pm_cap_r;
`else
      pm        <= 1'b0;
`endif
    end
  end

  // Scan prescaler and digit index; both keep running while blanked
  always_ff @(posedge Clk) begin
    if (reset) begin
      pre_r <= '0;
      idx_r <= 3'd0;
    end else if (pre_r == PRE_MAX) begin
      pre_r <= '0;
      if (idx_r >= 3'd5) begin
        idx_r <= 3'd0;
      end else begin
        idx_r <= idx_r + 3'd1;
      end
    end else begin
      pre_r <= pre_r + PRE_W'(1);
    end
  end

  // Digit select; seg and dig_en both derive from idx_r so they switch together
  always_comb begin
    cur_digit_s = 4'd0;
    dig_en      = 6'b000000;
    case (idx_r)
      3'd0:    cur_digit_s = disp_r[0];
      3'd1:    cur_digit_s = disp_r[1];
      3'd2:    cur_digit_s = disp_r[2];
      3'd3:    cur_digit_s = disp_r[3];
      3'd4:    cur_digit_s = disp_r[4];
      3'd5:    cur_digit_s = disp_r[5];
      default: cur_digit_s = 4'd0;
    endcase
    if (blank) begin
      dig_en = 6'b000000;
    end else begin
      dig_en = 6'b000001 << idx_r;
    end
    seg = seg_decode(cur_digit_s);
  end

endmodule

// File: tb/tb_time_display_scan.sv
module tb_time_display_scan;

  localparam int SD = 8;

  logic       Clk = 1'b0;
  logic       reset;
  logic [5:0] seconds, minutes, hours;
  logic       sample_req, blank;
  logic       busy, done, range_err, pm;
  logic [6:0] seg;
  logic [5:0] dig_en;

  typedef struct packed {
    logic [23:0] dig;
    logic        pm;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  time_display_scan #(.SCAN_DIV(SD)) dut (
    .Clk(Clk), .reset(reset), .seconds(seconds), .minutes(minutes),
    .hours(hours), .sample_req(sample_req), .blank(blank), .busy(busy),
    .done(done), .range_err(range_err), .seg(seg), .dig_en(dig_en), .pm(pm)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0111111;
      4'd1:    return 7'b0000110;
      4'd2:    return 7'b1011011;
      4'd3:    return 7'b1001111;
      4'd4:    return 7'b1100110;
      4'd5:    return 7'b1101101;
      4'd6:    return 7'b1111101;
      4'd7:    return 7'b0000111;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1101111;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic int map_h(input int h);
`ifdef TWELVE_HOUR_EN
    if (h == 0) return 12;
    if (h > 12) return h - 12;
`endif
    return h;
  endfunction

  function automatic exp_t model(input int h, input int m, input int s);
    exp_t e;
    int   hm;
    hm = map_h(h);
    e.dig[3:0]   = 4'(s % 10);
    e.dig[7:4]   = 4'(s / 10);
    e.dig[11:8]  = 4'(m % 10);
    e.dig[15:12] = 4'(m / 10);
    e.dig[19:16] = 4'(hm % 10);
    e.dig[23:20] = 4'(hm / 10);
`ifdef TWELVE_HOUR_EN
    e.pm = (h >= 12);
`else
    e.pm = 1'b0;
`endif
    return e;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Watch one full scan and compare every digit position's segments
  task automatic read_display(input logic [23:0] edig, input string tag);
    logic [6:0] obs [6];
    for (int p = 0; p < 6; p++) obs[p] = 7'bxxxxxxx;
    repeat (6 * SD) begin
      for (int p = 0; p < 6; p++) begin
        if (dig_en == (6'b000001 << p)) obs[p] = seg;
      end
      tick();
    end
    for (int p = 0; p < 6; p++) begin
      check_eq($sformatf("%s_d%0d", tag, p), {25'd0, obs[p]}, {25'd0, seg_of(edig[4*p +: 4])});
    end
  endtask

  task automatic do_capture(input int h, input int m, input int s, input string tag);
    exp_t e;
    int   t, edges, busy_cnt;
    e = model(h, m, s);
    t = s / 10;
    if (m / 10 > t) t = m / 10;
    if (map_h(h) / 10 > t) t = map_h(h) / 10;
    hours = 6'(h); minutes = 6'(m); seconds = 6'(s);
    sample_req = 1'b1;
    sb_q.push_back(e);
    tick();
    sample_req = 1'b0;
    edges = 0;
    busy_cnt = 0;
    while (!done && edges < 40) begin
      if (busy) busy_cnt++;
      tick();
      edges++;
    end
    check_eq({tag, "_latency"}, edges, t + 2);
    check_eq({tag, "_busy_cycles"}, busy_cnt, t + 1);
    check_eq({tag, "_sb_depth"}, sb_q.size(), 1);
    if (sb_q.size() > 0) e = sb_q.pop_front();
    tick();
    check_eq({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check_eq({tag, "_pm"}, {31'd0, pm}, {31'd0, e.pm});
    read_display(e.dig, tag);
  endtask

  initial begin
    exp_t e;
    exp_t last;
    int   dones, rises;
    logic busy_prev;

    reset = 1'b1; sample_req = 1'b0; blank = 1'b0;
    seconds = 6'd0; minutes = 6'd0; hours = 6'd0;
    tick(); tick();
    // reset wins over a legal request in the same cycle
    hours = 6'd1; sample_req = 1'b1;
    tick();
    reset = 1'b0; sample_req = 1'b0;
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    check_eq("rst_range_err", {31'd0, range_err}, 32'd0);
    check_eq("rst_pm", {31'd0, pm}, 32'd0);

    // scan walk after reset: every digit shows 0
    for (int i = 0; i < 6 * SD; i++) begin
      check_eq($sformatf("walk_en_%0d", i), {26'd0, dig_en}, {26'd0, 6'b000001 << (i / SD)});
      check_eq($sformatf("walk_seg_%0d", i), {25'd0, seg}, {25'd0, 7'b0111111});
      if (i == 0) check_eq("walk_busy", {31'd0, busy}, 32'd0);
      tick();
    end

    blank = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("blank_en", {26'd0, dig_en}, 32'd0);
    end
    blank = 1'b0;

    do_capture(23, 59, 59, "t235959");
    last = model(23, 59, 59);

    // out-of-range seconds is rejected and leaves the display alone
    hours = 6'd0; minutes = 6'd0; seconds = 6'd61; sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    check_eq("rng_pulse", {31'd0, range_err}, 32'd1);
    check_eq("rng_busy", {31'd0, busy}, 32'd0);
    tick();
    check_eq("rng_pulse_end", {31'd0, range_err}, 32'd0);
    check_eq("rng_busy2", {31'd0, busy}, 32'd0);
    check_eq("rng_done", {31'd0, done}, 32'd0);
    read_display(last.dig, "rng_unch");

    // request held high: acceptances at edges 0, 8, 16 only
    e = model(12, 34, 56);
    hours = 6'd12; minutes = 6'd34; seconds = 6'd56; sample_req = 1'b1;
    for (int k = 0; k < 3; k++) sb_q.push_back(e);
    dones = 0; rises = 0; busy_prev = 1'b0;
    for (int k = 0; k < 24; k++) begin
      tick();
      if (done) begin
        dones++;
        if (sb_q.size() > 0) last = sb_q.pop_front();
      end
      if (busy && !busy_prev) rises++;
      busy_prev = busy;
    end
    sample_req = 1'b0;
    check_eq("held_dones", dones, 3);
    check_eq("held_accepts", rises, 3);
    check_eq("held_sb_empty", sb_q.size(), 0);
    tick();
    check_eq("held_idle", {31'd0, busy}, 32'd0);
    check_eq("held_pm", {31'd0, pm}, {31'd0, last.pm});
    read_display(last.dig, "held");

    do_capture(0, 5, 0, "t000500");
    do_capture(13, 5, 0, "t130500");

    // reset on the second CONV edge aborts the conversion
    hours = 6'd20; minutes = 6'd40; seconds = 6'd50; sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("abort_en", {26'd0, dig_en}, 32'd1);
    check_eq("abort_seg", {25'd0, seg}, {25'd0, 7'b0111111});
    check_eq("abort_busy", {31'd0, busy}, 32'd0);
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) dones++;
      tick();
    end
    check_eq("abort_no_done", dones, 0);
    read_display(24'h000000, "abort_zero");

    check_eq("final_sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
